lshift_norm_ctrl: RTL and testbench
===================================

Name: lshift_norm_ctrl

Overview:
Sequencer for the 16-bit left shifter in the datapath. It normalises an operand: it loads the operand into the shifter, then shifts left until bit 15 is 1 or a shift limit is reached. It reports the shift count, a zero flag and a saturation flag. It sits between the top-level controller (start/done handshake) and the shifter's ld / shift_enable / clear pins.

Parameters:
WIDTH, 16, shifter width; the count register is clog2(WIDTH) bits wide.
MAX_SHIFT, 15, maximum shifts per operation; must satisfy 1 <= MAX_SHIFT <= WIDTH-1.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
rst  input  1  asynchronous, active-low reset.
start  input  1  request a normalisation; sampled only in IDLE.
abort  input  1  cancel the current operation; highest priority.
in_is_zero  input  1  operand presented to the shifter's input bus is 0; sampled with start.
sh_msb  input  1  shifter output bit 15.
sh_ld  output  1  shifter ld strobe.
sh_shift  output  1  shifter shift_enable strobe.
sh_clr  output  1  shifter synchronous clear (active-high).
ready  output  1  high in IDLE.
done  output  1  one-cycle completion pulse.
shift_cnt  output  clog2(WIDTH)  number of shifts performed.
zero  output  1  operand was zero.
sat  output  1  stopped at MAX_SHIFT with sh_msb still 0.

Behaviour:
- States:
  - IDLE: ready=1.
  - LOAD: sh_ld=1.
  - SHIFT: decision and shift cycles.
  - DONE: done=1.
  - CLR: sh_clr=1.
- Strobes are Moore outputs decoded from state; the exception is sh_shift, which is combinational in SHIFT.
- Reset (rst=0, asynchronous): state=IDLE; shift_cnt=0, zero=0, sat=0; all strobes 0; ready=1.
- IDLE:
  - start=1 and abort=0 → LOAD; clear shift_cnt and sat; latch zero<=in_is_zero.
  - abort=1 → stay in IDLE (abort wins over start).
- LOAD: one cycle; the shifter captures the operand on the exiting edge → SHIFT.
- SHIFT, evaluated each cycle:
  - stop = zero | sh_msb | (shift_cnt == MAX_SHIFT).
  - stop=0: sh_shift=1, shift_cnt++, stay in SHIFT.
  - stop=1: sh_shift=0 → DONE; sat<=(shift_cnt==MAX_SHIFT) & ~sh_msb & ~zero.
- DONE: done=1 for exactly one cycle → IDLE. shift_cnt, zero and sat hold until the next accepted start.
- abort=1 in LOAD, SHIFT or DONE → CLR (no done pulse). CLR lasts one cycle with sh_clr=1, then → IDLE; shift_cnt and sat are zeroed on entry to CLR.
- Latency for an operand with k leading zeros (k <= MAX_SHIFT), counting edges after the edge that samples start:
  - edge 1: load;
  - edges 2..k+1: shifts;
  - done high during cycle k+3.
- Zero operand: no shifts; done in cycle 3; shift_cnt=0, zero=1.
- start while not in IDLE is ignored; there is no queueing.
- shift_cnt never exceeds MAX_SHIFT and never wraps.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE, LOAD, SHIFT, DONE, CLR), 3 bits;
  - the count-width function clog2(WIDTH).
- One sub-module, shift_count_reg: up-counter with synchronous clear, enable and async active-low reset. Its terminal-compare output (== MAX_SHIFT) feeds the stop logic.
- The FSM stays in lshift_norm_ctrl.

Test Plan:
- Operand 0x8000, start pulse → sh_ld for 1 cycle, no sh_shift, done in cycle 3, shift_cnt=0, zero=0, sat=0.
- Operand 0x0001 with default MAX_SHIFT=15 → 15 consecutive sh_shift cycles, done in cycle 18, shift_cnt=15, sat=0, shifter output 0x8000.
- Operand 0x0000 (in_is_zero=1) → no sh_shift, done in cycle 3, shift_cnt=0, zero=1.
- MAX_SHIFT=4, operand 0x0100 → 4 shifts, done in cycle 7, shift_cnt=4, sat=1, shifter output 0x1000.
- Operand 0x0010, abort after the 2nd shift → CLR with sh_clr=1 for 1 cycle, then IDLE, no done, shift_cnt=0. Also: start and abort together in IDLE → stays IDLE with no sh_ld.
- rst asserted (low) mid-SHIFT → state returns to IDLE immediately, without waiting for a clock edge; outputs cleared, ready=1. A following start with 0x4000 → shift_cnt=1, done in cycle 4.

Source files
------------

// File: rtl/lshift_norm_ctrl_pkg.sv
// Shared encodings and sizing helper for the left-shift normaliser sequencer.
package lshift_norm_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_SHIFT = 3'd2,
      ST_DONE  = 3'd3,
      ST_CLR   = 3'd4
   } state_t;

   // Count register width: ceil(log2(w)), never less than one bit.
   function automatic int cnt_width(input int w);
      int r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((1 << r) < w) r = r + 1;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/lshift_norm_ctrl_shift_count_reg.sv
// Saturating shift counter: sync clear beats enable, holds at MAX_VAL.
// Zero latency on at_max (decoded from the register); no backpressure.
module shift_count_reg #(
   parameter int CW      = 4,
   parameter int MAX_VAL = 15
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   output logic [CW-1:0] cnt,
   output logic          at_max
);

   localparam logic [CW-1:0] MAX_C = CW'(MAX_VAL);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != MAX_C)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt    = cnt_q;
   assign at_max = (cnt_q == MAX_C);

endmodule

// File: rtl/lshift_norm_ctrl.sv
// Normalise sequencer: load operand, shift left until msb set or MAX_SHIFT reached.
// done k+3 cycles after start for k leading zeros; start ignored unless ready.
module lshift_norm_ctrl
   import lshift_norm_ctrl_pkg::*;
#(
   parameter  int WIDTH     = 16,
   parameter  int MAX_SHIFT = 15,
   localparam int CW        = cnt_width(WIDTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic          in_is_zero,
   input  logic          sh_msb,
   output logic          sh_ld,
   output logic          sh_shift,
   output logic          sh_clr,
   output logic          ready,
   output logic          done,
   output logic [CW-1:0] shift_cnt,
   output logic          zero,
   output logic          sat
);

   state_t state_q;
   state_t state_d;
   logic   zero_q;
   logic   zero_d;
   logic   sat_q;
   logic   sat_d;
   logic   cnt_clr;
   logic   cnt_en;
   logic   at_max;
   logic   stop;
   logic   busy;

   shift_count_reg #(
      .CW      (CW),
      .MAX_VAL (MAX_SHIFT)
   ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr    (cnt_clr),
      .en     (cnt_en),
      .cnt    (shift_cnt),
      .at_max (at_max)
   );

   assign stop = zero_q | sh_msb | at_max;
   assign busy = (state_q == ST_LOAD) || (state_q == ST_SHIFT) || (state_q == ST_DONE);

   always_comb begin
      state_d  = state_q;
      zero_d   = zero_q;
      sat_d    = sat_q;
      cnt_clr  = 1'b0;
      cnt_en   = 1'b0;
      sh_shift = 1'b0;

      // Abort outranks every other transition while an operation is in flight.
      if (busy && abort) begin
         state_d = ST_CLR;
         cnt_clr = 1'b1;
         sat_d   = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start && !abort) begin
                  state_d = ST_LOAD;
                  cnt_clr = 1'b1;
                  sat_d   = 1'b0;
                  zero_d  = in_is_zero;
               end
            end
            ST_LOAD: begin
               state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
               if (stop) begin
                  state_d = ST_DONE;
                  sat_d   = at_max & ~sh_msb & ~zero_q;
               end else begin
                  sh_shift = 1'b1;
                  cnt_en   = 1'b1;
               end
            end
            ST_DONE: begin
               state_d = ST_IDLE;
            end
            ST_CLR: begin
               state_d = ST_IDLE;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_IDLE;
         zero_q  <= 1'b0;
         sat_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         zero_q  <= zero_d;
         sat_q   <= sat_d;
      end
   end

   assign ready = (state_q == ST_IDLE);
   assign sh_ld = (state_q == ST_LOAD);
   assign done  = (state_q == ST_DONE);
   assign sh_clr = (state_q == ST_CLR);
   assign zero  = zero_q;
   assign sat   = sat_q;

endmodule

// File: tb/tb_lshift_norm_ctrl.sv
// Directed bench: two sequencers (MAX_SHIFT 15 and 4) each driving a shifter model.
module tb_lshift_norm_ctrl;

   logic        clk;
   logic        rst;
   logic [1:0]  start;
   logic [1:0]  abort;
   logic [1:0]  in_zero;
   logic [1:0]  msb;
   logic [1:0]  sh_ld;
   logic [1:0]  sh_shift;
   logic [1:0]  sh_clr;
   logic [1:0]  ready;
   logic [1:0]  done;
   logic [1:0]  zero;
   logic [1:0]  sat;
   logic [3:0]  cnt [2];
   logic [15:0] op [2];
   logic [15:0] sh_reg [2];

   int checks;
   int errors;

   lshift_norm_ctrl #(.WIDTH(16), .MAX_SHIFT(15)) u_dut0 (
      .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]),
      .in_is_zero(in_zero[0]), .sh_msb(msb[0]), .sh_ld(sh_ld[0]),
      .sh_shift(sh_shift[0]), .sh_clr(sh_clr[0]), .ready(ready[0]),
      .done(done[0]), .shift_cnt(cnt[0]), .zero(zero[0]), .sat(sat[0])
   );

   lshift_norm_ctrl #(.WIDTH(16), .MAX_SHIFT(4)) u_dut1 (
      .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]),
      .in_is_zero(in_zero[1]), .sh_msb(msb[1]), .sh_ld(sh_ld[1]),
      .sh_shift(sh_shift[1]), .sh_clr(sh_clr[1]), .ready(ready[1]),
      .done(done[1]), .shift_cnt(cnt[1]), .zero(zero[1]), .sat(sat[1])
   );

   // Shifter model: clear, load, then shift-left, in that priority.
   for (genvar g = 0; g < 2; g++) begin : g_shifter
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) sh_reg[g] <= '0;
         else if (sh_clr[g]) sh_reg[g] <= '0;
         else if (sh_ld[g]) sh_reg[g] <= op[g];
         else if (sh_shift[g]) sh_reg[g] <= {sh_reg[g][14:0], 1'b0};
      end
      assign msb[g] = sh_reg[g][15];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input int idx, input logic [15:0] operand, input string tag,
                         input int e_cyc, input int e_sh, input int e_cnt,
                         input int e_zero, input int e_sat, input logic [15:0] e_reg);
      int cyc;
      int n_ld;
      int n_sh;
      cyc  = 0;
      n_ld = 0;
      n_sh = 0;
      op[idx]      = operand;
      in_zero[idx] = (operand == 16'h0);
      start[idx]   = 1'b1;
      tick();
      start[idx]   = 1'b0;
      for (int c = 1; c <= 40; c++) begin
         if (sh_ld[idx]) n_ld++;
         if (sh_shift[idx]) n_sh++;
         if (done[idx]) begin
            cyc = c;
            break;
         end
         tick();
      end
      check({tag, "_done_cycle"}, cyc, e_cyc);
      check({tag, "_ld_pulses"}, n_ld, 1);
      check({tag, "_shift_pulses"}, n_sh, e_sh);
      check({tag, "_shift_cnt"}, 32'(cnt[idx]), e_cnt);
      check({tag, "_zero"}, 32'(zero[idx]), e_zero);
      check({tag, "_sat"}, 32'(sat[idx]), e_sat);
      check({tag, "_shifter"}, 32'(sh_reg[idx]), 32'(e_reg));
      tick();
      check({tag, "_ready_after"}, 32'(ready[idx]), 1);
      check({tag, "_done_1cyc"}, 32'(done[idx]), 0);
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst     = 1'b0;
      start   = '0;
      abort   = '0;
      in_zero = '0;
      op[0]   = '0;
      op[1]   = '0;
      #12;
      check("rst_ready", 32'(ready[0]), 1);
      check("rst_strobes", 32'({sh_ld[0], sh_shift[0], sh_clr[0], done[0]}), 0);
      check("rst_flags", 32'({cnt[0], zero[0], sat[0]}), 0);
      rst = 1'b1;
      tick();

      run_op(0, 16'h8000, "msb_set", 3, 0, 0, 0, 0, 16'h8000);
      run_op(0, 16'h0001, "lsb_only", 18, 15, 15, 0, 0, 16'h8000);
      run_op(0, 16'h0000, "zero_op", 3, 0, 0, 1, 0, 16'h0000);
      run_op(1, 16'h0100, "sat_max4", 7, 4, 4, 0, 1, 16'h1000);

      // Abort after the second shift.
      op[0] = 16'h0010;
      in_zero[0] = 1'b0;
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      tick();
      tick();
      tick();
      check("abort_cnt_before", 32'(cnt[0]), 2);
      abort[0] = 1'b1;
      tick();
      abort[0] = 1'b0;
      check("abort_clr", 32'(sh_clr[0]), 1);
      check("abort_cnt_zero", 32'(cnt[0]), 0);
      check("abort_no_done", 32'(done[0]), 0);
      tick();
      check("abort_ready", 32'(ready[0]), 1);
      check("abort_clr_gone", 32'({sh_clr[0], done[0]}), 0);

      // Start together with abort in IDLE is dropped.
      start[0] = 1'b1;
      abort[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      abort[0] = 1'b0;
      check("start_abort_no_ld", 32'(sh_ld[0]), 0);
      check("start_abort_ready", 32'(ready[0]), 1);

      // Asynchronous reset in the middle of shifting.
      op[0] = 16'h0001;
      start[0] = 1'b1;
      tick();
      start[0] = 1'b0;
      tick();
      tick();
      tick();
      #2;
      rst = 1'b0;
      #1;
      check("arst_ready", 32'(ready[0]), 1);
      check("arst_cnt", 32'(cnt[0]), 0);
      check("arst_strobes", 32'({sh_ld[0], sh_shift[0], sh_clr[0], done[0]}), 0);
      tick();
      rst = 1'b1;
      tick();
      run_op(0, 16'h4000, "after_rst", 4, 1, 1, 0, 0, 16'h8000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
